// File: rtl/sound_pkg.sv
// sound_pkg: shared register offsets, volume codes and read-back masks for the sound channels
package sound_pkg;
   localparam logic [15:0] NR30_OFS = 16'd0;
   localparam logic [15:0] NR31_OFS = 16'd1;
   localparam logic [15:0] NR32_OFS = 16'd2;
   localparam logic [15:0] NR33_OFS = 16'd3;
   localparam logic [15:0] NR34_OFS = 16'd4;
   localparam logic [15:0] NUM_REGS = 16'd5;
   typedef enum logic [1:0] {VOL_MUTE, VOL_FULL, VOL_HALF, VOL_QUARTER} vol_e;
   // Unused/write-only bits read back as ones.
   localparam logic [7:0] NR30_RMASK = 8'h7F;
   localparam logic [7:0] NR31_RMASK = 8'hFF;
   localparam logic [7:0] NR32_RMASK = 8'h9F;
   localparam logic [7:0] NR33_RMASK = 8'hFF;
   localparam logic [7:0] NR34_RMASK = 8'hBF;
   function automatic logic [7:0] vol_scale(input logic [7:0] s, input vol_e v);
      return v == VOL_MUTE ? 8'd0 : v == VOL_FULL ? s : v == VOL_HALF ? s >> 1 : s >> 2;
   endfunction
endpackage

// File: rtl/sound_length_counter.sv
// sound_length_counter: reusable length down-counter that silences a channel at zero
//   clk, rst          clock, asynchronous active-high reset
//   load, load_value  synchronous load, wins over a tick in the same cycle
//   tick, en          decrement strobe and length enable
//   count, expire     current count; expire marks the 1 -> 0 decrement
module sound_length_counter #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         tick,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         expire
);
   assign expire = tick && en && count == W'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (load) count <= load_value;
      else if (tick && en && count != '0) count <= count - W'(1);
endmodule

// File: rtl/sound_wave_channel.sv
// sound_wave_channel: wave-table sound channel with register/wave-RAM bus, length counter and volume shift
//   I_CLK, I_RESET             clock, asynchronous active-high reset
//   I_TICK, I_LEN_TICK         frequency-timer strobe and 256 Hz length strobe
//   I_IOREG_*                  register bus, active-low strobes
//   O_IOREG_RDATA, O_IOREG_HIT combinational read data and read-hit flag
//   O_CH_ON, O_WAVEFORM        channel active and registered output sample
module sound_wave_channel
   import sound_pkg::*;
#(
   parameter int          SAMPLE_BITS = 4,
   parameter int          DEPTH       = 32,
   parameter int          OUT_W       = 20,
   parameter logic [15:0] REG_BASE    = 16'hFF1A,
   parameter logic [15:0] WAVE_BASE   = 16'hFF30
) (
   input  logic             I_CLK,
   input  logic             I_RESET,
   input  logic             I_TICK,
   input  logic             I_LEN_TICK,
   input  logic [15:0]      I_IOREG_ADDR,
   input  logic [7:0]       I_IOREG_WDATA,
   input  logic             I_IOREG_WE_L,
   input  logic             I_IOREG_RE_L,
   output logic [7:0]       O_IOREG_RDATA,
   output logic             O_IOREG_HIT,
   output logic             O_CH_ON,
   output logic [OUT_W-1:0] O_WAVEFORM
);
   localparam int PW  = $clog2(DEPTH);
   localparam int NB  = DEPTH * SAMPLE_BITS / 8;
   localparam int AW  = $clog2(NB);
   localparam int NIB = SAMPLE_BITS == 4 ? 1 : 0;
   localparam int WSH = OUT_W - SAMPLE_BITS - 2;
   logic [7:0] ram [NB];
   logic dac_en, len_en, on, we, reg_hit, wave_hit;
   logic wr30, wr31, wr32, wr33, wr34, trig, len_load, len_expire;
   vol_e vol;
   logic [15:0] reg_off, wave_off;
   logic [AW-1:0] wave_idx;
   logic [10:0] freq, timer;
   logic [PW-1:0] ptr, nptr;
   logic [SAMPLE_BITS-1:0] sbuf, nsample, vsample;
   logic [8:0] len_cnt, len_value;
   logic [OUT_W-1:0] wave_q;
   assign we       = !I_IOREG_WE_L;
   assign reg_off  = I_IOREG_ADDR - REG_BASE;
   assign wave_off = I_IOREG_ADDR - WAVE_BASE;
   assign reg_hit  = reg_off < NUM_REGS;
   assign wave_hit = wave_off < 16'(NB);
   assign wave_idx = AW'(wave_off);
   assign wr30 = we && reg_hit && reg_off == NR30_OFS;
   assign wr31 = we && reg_hit && reg_off == NR31_OFS;
   assign wr32 = we && reg_hit && reg_off == NR32_OFS;
   assign wr33 = we && reg_hit && reg_off == NR33_OFS;
   assign wr34 = we && reg_hit && reg_off == NR34_OFS;
   assign trig = wr34 && I_IOREG_WDATA[7] && dac_en;
   // 4-bit samples: even index is the high nibble of its byte.
   assign nptr    = ptr + PW'(1);
   assign nsample = SAMPLE_BITS'(ram[AW'(nptr >> NIB)] >> ((NIB == 1 && !nptr[0]) ? 4 : 0));
   assign vsample = SAMPLE_BITS'(vol_scale(8'(sbuf), vol));
   // A trigger landing on the expiring length tick still reloads the full length.
   assign len_load  = wr31 || (trig && (len_cnt == 9'd0 || len_expire));
   assign len_value = wr31 ? 9'd256 - {1'b0, I_IOREG_WDATA} : 9'd256;
   sound_length_counter #(.W(9)) u_len (
      .clk(I_CLK), .rst(I_RESET), .load(len_load), .load_value(len_value),
      .tick(I_LEN_TICK), .en(len_en), .count(len_cnt), .expire(len_expire)
   );
   assign O_IOREG_RDATA = wave_hit ? ram[wave_idx] :
                          !reg_hit ? 8'h00 :
                          reg_off == NR30_OFS ? ({dac_en, 7'd0} | NR30_RMASK) :
                          reg_off == NR31_OFS ? NR31_RMASK :
                          reg_off == NR32_OFS ? ({1'b0, vol, 5'd0} | NR32_RMASK) :
                          reg_off == NR33_OFS ? NR33_RMASK :
                          ({1'b0, len_en, 6'd0} | NR34_RMASK);
   assign O_IOREG_HIT = (reg_hit || wave_hit) && !I_IOREG_RE_L;
   assign O_CH_ON     = on && dac_en;
   assign O_WAVEFORM  = O_CH_ON ? wave_q : '0;
   always_ff @(posedge I_CLK or posedge I_RESET)
      if (I_RESET) begin
         dac_en <= 1'b0;
         len_en <= 1'b0;
         vol    <= VOL_MUTE;
         freq   <= '0;
         on     <= 1'b0;
         timer  <= '0;
         ptr    <= '0;
         sbuf   <= '0;
         wave_q <= '0;
         for (int i = 0; i < NB; i++) ram[i] <= 8'h00;
      end else begin
         if (we && wave_hit) ram[wave_idx] <= I_IOREG_WDATA;
         if (wr30) dac_en <= I_IOREG_WDATA[7];
         if (wr32) vol <= vol_e'(I_IOREG_WDATA[6:5]);
         if (wr33) freq[7:0] <= I_IOREG_WDATA;
         if (wr34) begin
            freq[10:8] <= I_IOREG_WDATA[2:0];
            len_en     <= I_IOREG_WDATA[6];
         end
         on <= (wr30 && !I_IOREG_WDATA[7]) ? 1'b0 : trig ? 1'b1 : len_expire ? 1'b0 : on;
         if (trig) begin
            timer <= {I_IOREG_WDATA[2:0], freq[7:0]};
            ptr   <= '0;
            sbuf  <= '0;
         end else if (on && I_TICK) begin
            if (timer == 11'h7FF) begin
               timer <= freq;
               ptr   <= nptr;
               sbuf  <= nsample;
            end else timer <= timer + 11'd1;
         end
         wave_q <= OUT_W'(vsample) << WSH;
      end
endmodule
